// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// UART receiver clocked entirely by the system clock. A runtime divisor
// produces oversample ticks (OSR per bit). Each bit value is a majority vote of
// three samples around mid-bit. Finished frames go into a first-word-fall-
// through FIFO, together with their parity and framing error flags. The FIFO
// is drained over a valid/ready interface.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   en              receiver enable (0 aborts any frame in progress)
//   divisor         clk cycles per oversample tick (0/1 behave as 2)
//   length          data bits per frame, clamped to 5..DATA_W
//   parity_en       parity bit present
//   parity_odd      1 = odd parity, 0 = even parity
//   stop2           two stop bits checked
//   rx              asynchronous serial input, idle high
//   m_data          head-of-FIFO data, right-justified (0 when empty)
//   m_perr, m_ferr  head-of-FIFO parity / framing error (0 when empty)
//   m_valid         FIFO not empty
//   m_ready         consumer accepts the head entry
//   overrun         one-cycle pulse: a finished frame was dropped (FIFO full)
//   busy            receiver FSM is not idle
//   level           FIFO occupancy
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int OSR        = 16,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic [DIV_W-1:0]                  divisor,
    input  logic [3:0]                        length,
    input  logic                              parity_en,
    input  logic                              parity_odd,
    input  logic                              stop2,
    input  logic                              rx,
    output logic [DATA_W-1:0]                 m_data,
    output logic                              m_perr,
    output logic                              m_ferr,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic                              overrun,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level
);

    localparam int OS_W  = $clog2(OSR);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = DATA_W + 2;

    localparam logic [OS_W-1:0]  OS_ONE   = OS_W'(1);
    localparam logic [OS_W-1:0]  OS_SAMP0 = OS_W'(OSR / 2 - 1);
    localparam logic [OS_W-1:0]  OS_SAMP1 = OS_W'(OSR / 2);
    localparam logic [OS_W-1:0]  OS_VOTE  = OS_W'(OSR / 2 + 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OSR - 1);
    localparam logic [3:0]       LEN_MIN  = 4'd5;
    localparam logic [3:0]       LEN_MAX  = 4'(DATA_W);
    localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(2);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5,
        ST_PUSH   = 3'd6
    } state_t;

    // Majority of three samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Parity error: XOR over data and parity bit must equal the odd flag.
    function automatic logic parity_err(input logic [DATA_W-1:0] data,
                                        input logic              pbit,
                                        input logic              odd);
        return ((^data) ^ pbit) != odd;
    endfunction

    // ------------------------------------------------------------------ regs
    logic                r_rx_meta;
    logic                r_rx_s;
    logic [DIV_W-1:0]    r_tick_cnt;
    state_t              r_state;
    logic [OS_W-1:0]     r_os_cnt;     // index of the next tick within the bit
    logic [3:0]          r_bit_cnt;
    logic [1:0]          r_samp;
    logic [DATA_W-1:0]   r_data;
    logic                r_perr;
    logic                r_ferr;
    logic [3:0]          r_len;
    logic                r_par_en;
    logic                r_par_odd;
    logic                r_stop2;
    logic                r_busy;

    logic [ENT_W-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [LVL_W-1:0]    r_level;
    logic                r_m_valid;
    logic [DATA_W-1:0]   r_m_data;
    logic                r_m_perr;
    logic                r_m_ferr;
    logic                r_overrun;

    // ----------------------------------------------------------------- wires
    logic [DIV_W-1:0]    w_div_last;
    logic                w_tick;
    logic                w_vote_tick;
    logic                w_end_tick;
    logic                w_vote;
    logic [3:0]          w_len_clamp;
    logic [DATA_W-1:0]   w_vote_bit;

    logic                w_full;
    logic                w_pop;
    logic                w_push_req;
    logic                w_wr;
    logic                w_ovr;
    logic [PTR_W-1:0]    w_rptr_nxt;
    logic [LVL_W-1:0]    w_level_nxt;
    logic [ENT_W-1:0]    w_wdata;
    logic [ENT_W-1:0]    w_head_nxt;

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_div_last  = ((divisor < DIV_MIN) ? DIV_MIN : divisor) - DIV_ONE;
    assign w_tick      = (r_state != ST_IDLE) && (r_tick_cnt >= w_div_last);
    assign w_vote_tick = w_tick && (r_os_cnt == OS_VOTE);
    assign w_end_tick  = w_tick && (r_os_cnt == OS_LAST);
    // The third sample is taken live on the vote tick.
    assign w_vote      = maj3(r_samp[0], r_samp[1], r_rx_s);
    assign w_vote_bit  = {{(DATA_W-1){1'b0}}, w_vote};

    // Clamp the requested frame length into the supported range.
    always_comb begin
        w_len_clamp = length;
        if (length < LEN_MIN) begin
            w_len_clamp = LEN_MIN;
        end else if (length > LEN_MAX) begin
            w_len_clamp = LEN_MAX;
        end else begin
            w_len_clamp = length;
        end
    end

    // Oversample tick divider; held at zero while idle so each frame starts aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= {DIV_W{1'b0}};
        end else if (r_state == ST_IDLE) begin
            r_tick_cnt <= {DIV_W{1'b0}};
        end else if (r_tick_cnt >= w_div_last) begin
            r_tick_cnt <= {DIV_W{1'b0}};
        end else begin
            r_tick_cnt <= r_tick_cnt + DIV_ONE;
        end
    end

    // Receiver FSM: frame bit sequencing, sampling and error accumulation.
    // The start-edge detection cycle counts as tick 0 of the start bit, so
    // tick i of every bit lands i*divisor cycles after the bit edge and the
    // three vote samples straddle the bit centre.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_os_cnt  <= {OS_W{1'b0}};
            r_bit_cnt <= 4'd0;
            r_samp    <= 2'b11;
            r_data    <= {DATA_W{1'b0}};
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_len     <= LEN_MIN;
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
            r_stop2   <= 1'b0;
            r_busy    <= 1'b0;
        end else if (!en) begin
            r_state   <= ST_IDLE;
            r_os_cnt  <= {OS_W{1'b0}};
            r_bit_cnt <= 4'd0;
            r_busy    <= 1'b0;
        end else begin
            if (w_tick) begin
                if (r_os_cnt == OS_SAMP0) begin
                    r_samp[0] <= r_rx_s;
                end
                if (r_os_cnt == OS_SAMP1) begin
                    r_samp[1] <= r_rx_s;
                end
                r_os_cnt <= (r_os_cnt == OS_LAST) ? {OS_W{1'b0}} : r_os_cnt + OS_ONE;
            end
            case (r_state)
                ST_IDLE: begin
                    if (!r_rx_s) begin
                        r_state   <= ST_START;
                        r_busy    <= 1'b1;
                        r_os_cnt  <= OS_ONE;
                        r_bit_cnt <= 4'd0;
                        r_data    <= {DATA_W{1'b0}};
                        r_perr    <= 1'b0;
                        r_ferr    <= 1'b0;
                        r_len     <= w_len_clamp;
                        r_par_en  <= parity_en;
                        r_par_odd <= parity_odd;
                        r_stop2   <= stop2;
                    end
                end
                ST_START: begin
                    if (w_vote_tick && w_vote) begin
                        // Start bit did not hold low: treat as a glitch.
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_end_tick) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_vote_tick) begin
                        r_data <= r_data | (w_vote_bit << r_bit_cnt);
                    end
                    if (w_end_tick) begin
                        if (r_bit_cnt == (r_len - 4'd1)) begin
                            r_state <= r_par_en ? ST_PARITY : ST_STOP1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_vote_tick) begin
                        r_perr <= parity_err(r_data, w_vote, r_par_odd);
                    end
                    if (w_end_tick) begin
                        r_state <= ST_STOP1;
                    end
                end
                ST_STOP1: begin
                    if (w_vote_tick) begin
                        r_ferr <= r_ferr | ~w_vote;
                        // Single stop bit: push immediately so the next
                        // start edge is never missed.
                        if (!r_stop2) begin
                            r_state <= ST_PUSH;
                        end
                    end else if (w_end_tick && r_stop2) begin
                        r_state <= ST_STOP2;
                    end
                end
                ST_STOP2: begin
                    if (w_vote_tick) begin
                        r_ferr  <= r_ferr | ~w_vote;
                        r_state <= ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------ FIFO
    assign w_full     = (r_level == LVL_FULL);
    assign w_pop      = r_m_valid & m_ready;
    assign w_push_req = (r_state == ST_PUSH);
    // A full FIFO still accepts the frame when a pop frees a slot this cycle.
    assign w_wr       = w_push_req & (~w_full | w_pop);
    assign w_ovr      = w_push_req & ~w_wr;
    assign w_rptr_nxt = w_pop ? (r_rptr + PTR_ONE) : r_rptr;
    assign w_wdata    = {r_perr, r_ferr, r_data};

    // Next occupancy from the write/pop pair.
    always_comb begin
        w_level_nxt = r_level;
        case ({w_wr, w_pop})
            2'b10:   w_level_nxt = r_level + LVL_ONE;
            2'b01:   w_level_nxt = r_level - LVL_ONE;
            default: w_level_nxt = r_level;
        endcase
    end

    // Next head entry; the entry being written is forwarded when it becomes the head.
    always_comb begin
        w_head_nxt = {ENT_W{1'b0}};
        if (w_level_nxt == {LVL_W{1'b0}}) begin
            w_head_nxt = {ENT_W{1'b0}};
        end else if (w_wr && (r_wptr == w_rptr_nxt)) begin
            w_head_nxt = w_wdata;
        end else begin
            w_head_nxt = r_mem[w_rptr_nxt];
        end
    end

    // Frame storage; contents are only observed through valid entries.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= w_wdata;
        end
    end

    // FIFO pointers, occupancy and registered head/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr    <= {PTR_W{1'b0}};
            r_rptr    <= {PTR_W{1'b0}};
            r_level   <= {LVL_W{1'b0}};
            r_m_valid <= 1'b0;
            r_m_data  <= {DATA_W{1'b0}};
            r_m_perr  <= 1'b0;
            r_m_ferr  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            r_rptr    <= w_rptr_nxt;
            r_level   <= w_level_nxt;
            r_m_valid <= (w_level_nxt != {LVL_W{1'b0}});
            r_m_perr  <= w_head_nxt[ENT_W-1];
            r_m_ferr  <= w_head_nxt[ENT_W-2];
            r_m_data  <= w_head_nxt[DATA_W-1:0];
            r_overrun <= w_ovr;
        end
    end

    assign m_data  = r_m_data;
    assign m_perr  = r_m_perr;
    assign m_ferr  = r_m_ferr;
    assign m_valid = r_m_valid;
    assign overrun = r_overrun;
    assign busy    = r_busy;
    assign level   = r_level;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed bench for uart_rx_fifo with divisor=4, OSR=16 (64 clk per bit),
// FIFO depth 8. Frames are driven bit by bit on the falling clock edge and all
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int BIT_CLK = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] divisor;
    logic [3:0]  length;
    logic        parity_en;
    logic        parity_odd;
    logic        stop2;
    logic        rx;
    logic [7:0]  m_data;
    logic        m_perr;
    logic        m_ferr;
    logic        m_valid;
    logic        m_ready;
    logic        overrun;
    logic        busy;
    logic [3:0]  level;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int rise_cyc    = 0;
    int ovr_cnt     = 0;
    int start_cyc   = 0;
    int ovr_base    = 0;
    logic prev_valid = 1'b0;

    uart_rx_fifo #(
        .DATA_W     (8),
        .OSR        (16),
        .DIV_W      (16),
        .FIFO_DEPTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .divisor    (divisor),
        .length     (length),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .rx         (rx),
        .m_data     (m_data),
        .m_perr     (m_perr),
        .m_ferr     (m_ferr),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .overrun    (overrun),
        .busy       (busy),
        .level      (level)
    );

    always #5 clk = ~clk;

    // Free-running cycle count (posedges seen).
    always @(posedge clk) cyc <= cyc + 1;

    // Record m_valid rising cycle and count overrun pulse cycles.
    always @(negedge clk) begin
        if (m_valid && !prev_valid) rise_cyc <= cyc;
        if (overrun) ovr_cnt <= ovr_cnt + 1;
        prev_valid <= m_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive n bits of pat LSB first, one bit time each; called on a negedge.
    task automatic send_bits(input logic [15:0] pat, input int n);
        start_cyc = cyc;
        for (int i = 0; i < n; i++) begin
            rx = pat[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b1;
        divisor    = 16'd4;
        length     = 4'd8;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        stop2      = 1'b0;
        rx         = 1'b1;
        m_ready    = 1'b0;
        idle(3);

        // Reset state
        check("rst_m_data",  {24'd0, m_data}, 32'h0);
        check("rst_m_perr",  {31'd0, m_perr}, 32'h0);
        check("rst_m_ferr",  {31'd0, m_ferr}, 32'h0);
        check("rst_m_valid", {31'd0, m_valid}, 32'h0);
        check("rst_overrun", {31'd0, overrun}, 32'h0);
        check("rst_busy",    {31'd0, busy}, 32'h0);
        check("rst_level",   {28'd0, level}, 32'h0);
        rst = 1'b0;
        idle(10);

        // 1: 8N1 0xA5, clean frame, latency bound from the start edge
        send_bits({1'b1, 8'hA5, 1'b0}, 10);
        idle(4);
        check("t1_valid", {31'd0, m_valid}, 32'h1);
        check("t1_data",  {24'd0, m_data}, 32'hA5);
        check("t1_perr",  {31'd0, m_perr}, 32'h0);
        check("t1_ferr",  {31'd0, m_ferr}, 32'h0);
        check("t1_latency_le_616",
              {31'd0, (rise_cyc > start_cyc) && ((rise_cyc - start_cyc) <= 616)}, 32'h1);
        pop();
        idle(2);
        check("t1_empty_after_pop", {31'd0, m_valid}, 32'h0);

        // 2: 7E1 0x35 (four ones) with parity bit 1 -> parity error
        length     = 4'd7;
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        send_bits({1'b1, 1'b1, 7'h35, 1'b0}, 10);
        idle(40);
        check("t2_data", {24'd0, m_data}, 32'h35);
        check("t2_perr", {31'd0, m_perr}, 32'h1);
        check("t2_ferr", {31'd0, m_ferr}, 32'h0);
        pop();
        idle(4);

        // 3: 8N2 0x3C with second stop bit low -> framing error
        length    = 4'd8;
        parity_en = 1'b0;
        stop2     = 1'b1;
        send_bits({1'b0, 1'b1, 8'h3C, 1'b0}, 11);
        idle(200);
        check("t3_data",  {24'd0, m_data}, 32'h3C);
        check("t3_ferr",  {31'd0, m_ferr}, 32'h1);
        check("t3_perr",  {31'd0, m_perr}, 32'h0);
        check("t3_level", {28'd0, level}, 32'h1);
        pop();
        stop2 = 1'b0;
        idle(4);

        // 4: 16-clk low glitch -> rejected, nothing pushed
        rx = 1'b0;
        idle(16);
        rx = 1'b1;
        idle(4);
        check("t4_busy_during", {31'd0, busy}, 32'h1);
        idle(80);
        check("t4_busy_after", {31'd0, busy}, 32'h0);
        check("t4_level",      {28'd0, level}, 32'h0);
        check("t4_valid",      {31'd0, m_valid}, 32'h0);

        // en=0 mid-frame aborts the frame on the next cycle
        rx = 1'b0;
        idle(20);
        check("en_busy_before", {31'd0, busy}, 32'h1);
        en = 1'b0;
        idle(1);
        check("en_busy_off", {31'd0, busy}, 32'h0);
        rx = 1'b1;
        idle(10);
        en = 1'b1;
        idle(10);
        check("en_level", {28'd0, level}, 32'h0);

        // 5: nine frames with no consumer -> eight stored, one overrun
        ovr_base = ovr_cnt;
        for (int k = 1; k <= 9; k++) begin
            send_bits({1'b1, 8'(k), 1'b0}, 10);
            idle(20);
        end
        check("t5_level",   {28'd0, level}, 32'h8);
        check("t5_overrun", ovr_cnt - ovr_base, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("t5_drain_%0d", k), {24'd0, m_data}, k);
            pop();
        end
        check("t5_empty", {31'd0, m_valid}, 32'h0);
        check("t5_level_end", {28'd0, level}, 32'h0);

        // 6: reset mid-DATA with a frame already queued
        send_bits({1'b1, 8'h77, 1'b0}, 10);
        idle(20);
        check("t6_pre_valid", {31'd0, m_valid}, 32'h1);
        send_bits(16'b0000_0000_0000_1010, 4);
        rst = 1'b1;
        idle(1);
        check("t6_rst_valid",   {31'd0, m_valid}, 32'h0);
        check("t6_rst_level",   {28'd0, level}, 32'h0);
        check("t6_rst_busy",    {31'd0, busy}, 32'h0);
        check("t6_rst_data",    {24'd0, m_data}, 32'h0);
        check("t6_rst_overrun", {31'd0, overrun}, 32'h0);
        rst = 1'b0;
        idle(20);
        send_bits({1'b1, 8'h5A, 1'b0}, 10);
        idle(20);
        check("t6_data",  {24'd0, m_data}, 32'h5A);
        check("t6_perr",  {31'd0, m_perr}, 32'h0);
        check("t6_ferr",  {31'd0, m_ferr}, 32'h0);
        check("t6_level", {28'd0, level}, 32'h1);
        pop();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
